// File: rtl/module_7seg_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display.
// It holds the displayed value in an active register and stages CPU writes in a
// shadow register. The shadow is copied into the active register only at the end
// of a frame, so a write can never tear a frame. The controller steps the digit
// select every REFRESH_DIV cycles. Every anode is off for the first
// BLANK_CYCLES cycles of each slot (anti-ghosting). Optional leading-zero
// blanking suppresses unlit high-order digits.
module module_7seg_scan_ctrl #(
  parameter int BUS_WIDTH    = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  logic [4*BUS_WIDTH-1:0]   wr_data_i,
  input  logic                     lzb_en_i,
  output logic [BUS_WIDTH-1:0]     digit0_o,
  output logic [BUS_WIDTH-1:0]     digit1_o,
  output logic [BUS_WIDTH-1:0]     digit2_o,
  output logic [BUS_WIDTH-1:0]     digit3_o,
  output logic [1:0]               sel_o,
  output logic [3:0]               an_o,
  output logic                     pending_o,
  output logic                     frame_done_o
);

  localparam int DATA_W = 4 * BUS_WIDTH;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  // Write interface: wr_en_i is a single-cycle strobe with no ready. Every
  // strobe is accepted on the clock edge where it is high. The most recent
  // strobe before a commit wins.

  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [1:0]        sel_q,        sel_d;
  logic [3:0]        an_q,         an_d;
  logic [DATA_W-1:0] shadow_q,     shadow_d;
  logic [DATA_W-1:0] active_q,     active_d;
  logic              pending_q,    pending_d;
  logic              frame_done_q, frame_done_d;

  logic              end_slot;
  logic              commit;
  logic [3:0]        blank_vec;

  // Slot timing: the slot ends on the last count, and a frame ends at the end of slot 3.
  always_comb begin
    end_slot = 1'b0;
    commit   = 1'b0;
    cnt_d    = cnt_q + CNT_W'(1);
    sel_d    = sel_q;
    if (cnt_q == CNT_LAST) begin
      end_slot = 1'b1;
      cnt_d    = '0;
      sel_d    = sel_q + 2'd1;
    end
    commit = end_slot && (sel_q == 2'd3) && pending_q;
  end

  // Shadow/active double buffer. A write in the commit cycle keeps pending set.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    if (commit) begin
      active_d     = shadow_q;
      pending_d    = 1'b0;
      frame_done_d = 1'b1;
    end
    if (wr_en_i) begin
      shadow_d  = wr_data_i;
      pending_d = 1'b1;
    end
  end

  // Leading-zero blanking: digit k is dark when nibbles k..3 are all zero.
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[3] = lzb_en_i && (active_q[3*BUS_WIDTH +: BUS_WIDTH] == '0);
    blank_vec[2] = blank_vec[3] && (active_q[2*BUS_WIDTH +: BUS_WIDTH] == '0);
    blank_vec[1] = blank_vec[2] && (active_q[1*BUS_WIDTH +: BUS_WIDTH] == '0);
    blank_vec[0] = 1'b0;
  end

  // Anode pattern for the next cycle, computed from the next count and select.
  always_comb begin
    an_d = 4'b1111;
    if ((cnt_d >= CNT_BLANK) && !blank_vec[sel_d]) begin
      an_d[sel_d] = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      an_q         <= 4'b1111;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit0_o     = active_q[0*BUS_WIDTH +: BUS_WIDTH];
  assign digit1_o     = active_q[1*BUS_WIDTH +: BUS_WIDTH];
  assign digit2_o     = active_q[2*BUS_WIDTH +: BUS_WIDTH];
  assign digit3_o     = active_q[3*BUS_WIDTH +: BUS_WIDTH];
  assign sel_o        = sel_q;
  assign an_o         = an_q;
  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_module_7seg_scan_ctrl.sv
// Directed bench for module_7seg_scan_ctrl with REFRESH_DIV=8 and BLANK_CYCLES=2.
// cyc counts the clock edges since reset release, so slot = (cyc/8)%4 and
// cnt = cyc%8. A frame is 32 cycles, and a commit lands when cyc%32 becomes 0.
module tb_module_7seg_scan_ctrl;

  localparam int BW  = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          wr_en_i;
  logic [15:0]   wr_data_i;
  logic          lzb_en_i;
  logic [BW-1:0] digit0_o, digit1_o, digit2_o, digit3_o;
  logic [1:0]    sel_o;
  logic [3:0]    an_o;
  logic          pending_o;
  logic          frame_done_o;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int fd_cnt = 0;

  module_7seg_scan_ctrl #(
    .BUS_WIDTH   (BW),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .lzb_en_i    (lzb_en_i),
    .digit0_o    (digit0_o),
    .digit1_o    (digit1_o),
    .digit2_o    (digit2_o),
    .digit3_o    (digit3_o),
    .sel_o       (sel_o),
    .an_o        (an_o),
    .pending_o   (pending_o),
    .frame_done_o(frame_done_o)
  );

  // Clock and reset.
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (frame_done_o) fd_cnt++;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 64; i++) begin
      if ((cyc % 32) == target) break;
      tick();
    end
  endtask

  task automatic write(input logic [15:0] val);
    wr_en_i   = 1'b1;
    wr_data_i = val;
    tick();
    wr_en_i   = 1'b0;
    wr_data_i = 16'h0000;
  endtask

  function automatic logic [15:0] digits();
    return {digit3_o, digit2_o, digit1_o, digit0_o};
  endfunction

  // Checks one frame of the scan. lit[s] says whether slot s should light.
  task automatic check_frame(input string tag, input logic [3:0] lit);
    int s, c;
    logic [3:0] exp_an;
    for (int i = 0; i < 32; i++) begin
      tick();
      s = (cyc / DIV) % 4;
      c = cyc % DIV;
      exp_an = 4'b1111;
      if (c >= BLK && lit[s]) exp_an[s] = 1'b0;
      chk({tag, "_sel"}, 32'(sel_o), 32'(s));
      chk({tag, "_an"}, 32'(an_o), 32'(exp_an));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"},      32'(an_o),         32'h0000_000F);
    chk({tag, "_sel"},     32'(sel_o),        32'h0);
    chk({tag, "_digits"},  32'(digits()),     32'h0);
    chk({tag, "_pending"}, 32'(pending_o),    32'h0);
    chk({tag, "_fdone"},   32'(frame_done_o), 32'h0);
  endtask

  initial begin
    rst_n_i   = 1'b0;
    wr_en_i   = 1'b0;
    wr_data_i = 16'h0000;
    lzb_en_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    rst_n_i = 1'b1;
    cyc     = 0;

    // Free scan with active = 0 and lzb off: every slot lights.
    check_frame("scan0", 4'b1111);

    // Write 0x1234 during slot 1, then commit at the frame end.
    run_to(10);
    write(16'h1234);
    chk("wr1_pending", 32'(pending_o), 32'h1);
    chk("wr1_hold",    32'(digits()),  32'h0);
    run_to(31);
    chk("wr1_hold_s3",  32'(digits()),     32'h0);
    chk("wr1_pend_s3",  32'(pending_o),    32'h1);
    chk("wr1_fd_pre",   32'(frame_done_o), 32'h0);
    tick();
    chk("wr1_commit",   32'(digits()),     32'h1234);
    chk("wr1_pend_clr", 32'(pending_o),    32'h0);
    chk("wr1_fd",       32'(frame_done_o), 32'h1);
    tick();
    chk("wr1_fd_off",   32'(frame_done_o), 32'h0);
    run_to(0);
    check_frame("scan1234", 4'b1111);

    // With two writes in one frame, the last write wins and one pulse is seen.
    run_to(5);
    write(16'hAAAA);
    run_to(12);
    write(16'h5555);
    fd_cnt = 0;
    run_to(0);
    chk("lww_digits", 32'(digits()),  32'h5555);
    chk("lww_pulses", 32'(fd_cnt),    32'h1);
    chk("lww_pend",   32'(pending_o), 32'h0);
    tick();
    chk("lww_fd_off", 32'(frame_done_o), 32'h0);

    // A write in the commit cycle: 0x1111 commits and 0x9999 stays pending.
    run_to(10);
    write(16'h1111);
    run_to(31);
    write(16'h9999);
    chk("cc_digits1", 32'(digits()),     32'h1111);
    chk("cc_pend1",   32'(pending_o),    32'h1);
    chk("cc_fd1",     32'(frame_done_o), 32'h1);
    fd_cnt = 0;
    run_to(31);
    chk("cc_hold",    32'(digits()),     32'h1111);
    tick();
    chk("cc_digits2", 32'(digits()),     32'h9999);
    chk("cc_pend2",   32'(pending_o),    32'h0);
    chk("cc_fd2",     32'(frame_done_o), 32'h1);
    chk("cc_pulses",  32'(fd_cnt),       32'h1);

    // Leading-zero blanking.
    run_to(5);
    write(16'h0050);
    run_to(0);
    chk("lzb_val50", 32'(digits()), 32'h0050);
    lzb_en_i = 1'b1;
    check_frame("lzb50", 4'b0011);
    run_to(5);
    write(16'h0000);
    run_to(0);
    chk("lzb_val00", 32'(digits()), 32'h0000);
    check_frame("lzb00", 4'b0001);
    lzb_en_i = 1'b0;
    check_frame("lzboff", 4'b1111);

    // Reset mid-slot with a write pending.
    run_to(3);
    write(16'hABCD);
    tick();
    chk("mid_pend", 32'(pending_o), 32'h1);
    rst_n_i = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    cyc     = 0;
    run_to(0);
    for (int i = 0; i < 33; i++) tick();
    chk("post_digits", 32'(digits()),  32'h0);
    chk("post_pend",   32'(pending_o), 32'h0);
    chk("post_sel",    32'(sel_o),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/module_7seg_scan_ctrl.md
Name: module_7seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment peripheral; sits directly upstream of the 4:1 digit mux and the segment decoder.
- Holds the displayed 16-bit value and drives the four per-digit nibbles plus the 2-bit select into the mux.
- Generates the active-low anode enables with inter-digit blanking and optional leading-zero blanking.
- Double-buffers CPU writes so the displayed value only changes on a frame boundary, which prevents digit tearing.

Parameters:
- BUS_WIDTH, 4, width of one digit nibble; matches the mux data width.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 100, cycles at the start of each slot during which all anodes are off (anti-ghosting).

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- wr_en_i  input  1  write strobe from the peripheral bus; one cycle per write.
- wr_data_i  input  4*BUS_WIDTH  value to display; nibble 0 = LSB = rightmost digit.
- lzb_en_i  input  1  leading-zero blank enable.
- digit0_o..digit3_o  output  BUS_WIDTH each  active nibbles to mux inputs a..d.
- sel_o  output  2  current digit index to mux select.
- an_o  output  4  anode enables, active-low.
- pending_o  output  1  shadow value waiting for commit.
- frame_done_o  output  1  one-cycle pulse on each commit.

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_n_i is asynchronous, active-low.
- Reset values: slot counter 0, sel_o=0, an_o=4'b1111, shadow and active registers 0, digitN_o=0, pending_o=0, frame_done_o=0.
- Reset mid-operation: a reset at any point, including with a pending write, returns every register to its reset value; the pending write is discarded.
- Slot counter:
  - cnt runs 0..REFRESH_DIV-1.
  - In the cycle with cnt==REFRESH_DIV-1 (end of slot), next cnt=0 and sel_o increments, wrapping 3->0.
- Anodes (registered, derived from next-state cnt/sel):
  - All 1 while cnt < BLANK_CYCLES.
  - Otherwise an_o[sel_o]=0 and the other three bits are 1.
  - A digit that is blanked (see leading-zero blanking) forces all anodes to 1 for its whole slot.
- Digit outputs:
  - digitN_o = active[N*BUS_WIDTH +: BUS_WIDTH].
  - Registered; they change only at commit.
- Write path:
  - wr_en_i=1 loads wr_data_i into shadow; pending_o=1 from the next cycle.
  - Multiple writes before a commit: last write wins.
- Commit:
  - Occurs on the edge where cnt==REFRESH_DIV-1 and sel_o==3 and pending_o==1.
  - On that edge: active<=shadow, pending_o<=0, frame_done_o=1 for the following cycle only.
  - No commit and no pulse when pending_o==0.
- Write in the commit cycle: the old shadow is committed, wr_data_i goes into shadow, and pending_o stays 1. The new value commits at the next frame end.
- Write-to-display latency: at most 4*REFRESH_DIV+1 cycles.
- Leading-zero blanking:
  - With lzb_en_i=1, digit k (k=1..3) is blanked when nibbles k..3 of active are all zero.
  - Digit 0 is never blanked.
  - Evaluated from active and the live lzb_en_i; takes effect in the next registered an_o update.
- sel_o and digitN_o are unaffected by blanking; only an_o is.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset: hold rst_n_i low, then release -> an_o=1111, sel_o=0, digits 0, pending_o=0, frame_done_o=0. Asserting reset mid-slot with pending_o=1 restores the same values immediately.
- Free scan, active=0x1234, lzb off:
  - sel_o steps 0,1,2,3,0 every 8 cycles.
  - In each slot, an_o=1111 for 2 cycles, then 1110 / 1101 / 1011 / 0111 for 6 cycles.
- Write 0x1234 during sel_o=1:
  - pending_o=1 next cycle; digits unchanged through sel_o=3.
  - After the last sel_o=3 cycle: digit0..3=4,3,2,1, pending_o=0, frame_done_o high for exactly 1 cycle.
- Writes 0xAAAA then 0x5555 in the same frame -> only 0x5555 appears at commit; exactly one frame_done_o pulse.
- Write 0x9999 in the commit cycle with shadow 0x1111 pending:
  - 0x1111 is committed and pending_o stays 1.
  - 0x9999 is committed one frame later.
- Leading-zero blanking, lzb_en_i=1:
  - active=0x0050 -> an_o stays 1111 during sel_o=2,3 slots; digits 1 and 0 are lit.
  - active=0x0000 -> only the digit-0 slot lights.
  - lzb_en_i=0 -> all four digits light.
